pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline stall/flush controller for the 5-stage core. Drives per-stage stall vector consumed by
//  pc_reg, if_id, id_ex, ex_mem, mem_wb. Sequences multi-cycle EX operations (mul/div) by holding
//  PC..EX for a programmed cycle count. On an exception, redirects fetch and flushes all pipe regs.
// PARAMETERS
//  CNT_W      6    width of multi-cycle length / countdown counter
//  ADDR_W     32   instruction address width for redirect target
// PORTS
//  clk           in   1       core clock, all state on rising edge
//  rst           in   1       asynchronous, active-low reset (rst==0 -> reset)
//  stallreq_id   in   1       ID load-use hazard request, level, same-cycle effect
//  ex_mc_start   in   1       one-cycle pulse: EX begins multi-cycle op
//  ex_mc_len     in   CNT_W   cycles the op needs; sampled with ex_mc_start
//  excp_req      in   1       exception/redirect request from MEM, one-cycle pulse
//  excp_pc       in   ADDR_W  handler address; sampled with excp_req
//  stall         out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
//  flush         out  1       clear all pipeline registers to NOP values
//  new_pc        out  ADDR_W  redirect target, valid when flush==1
//  mc_done       out  1       one-cycle pulse: EX multi-cycle result valid this cycle
//  busy          out  1       FSM not IDLE
//  stall_cycles  out  32      cumulative stalled cycles (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, new_pc=0; stall=0, flush=0, mc_done=0, busy=0, stall_cycles=0.
//  Reset mid-operation aborts any count/flush immediately; no mc_done, no flush after release.
//  States: IDLE, MC_RUN, MC_DONE, FLUSH (encodings in defines.v).
//  IDLE: excp_req -> FLUSH, latch new_pc<=excp_pc. Else ex_mc_start: len>=2 -> MC_RUN, cnt<=len-1;
//        len<=1 -> MC_DONE. Else stay.
//  MC_RUN: stall=6'b001111; cnt decrements each cycle; cnt==1 -> MC_DONE.
//        Total stalled cycles for op = len-1 (issue cycle + stalls = len cycles in EX).
//        excp_req -> FLUSH, cnt<=0, op abandoned, no mc_done. ex_mc_start ignored.
//  MC_DONE: mc_done=1 one cycle; stall from stallreq_id only; -> IDLE (excp_req -> FLUSH).
//  FLUSH: flush=1 exactly one cycle (registered, cycle after excp_req); stall=0; all requests
//        (incl. new excp_req, ex_mc_start) ignored; -> IDLE.
//  stall is combinational from state + stallreq_id:
//        MC_RUN: 6'b001111 (stallreq_id absorbed); IDLE/MC_DONE: stallreq_id ? 6'b000111 : 0;
//        FLUSH: 0. stall never asserted concurrently with flush.
//  Priority in any cycle: rst > excp_req > ex_mc_start > stallreq_id.
//  Simultaneous excp_req and ex_mc_start in IDLE: exception wins, op never starts.
//  Counter arithmetic unsigned CNT_W bits; len=0 treated as 1; no wrap (counts down to 1 only).
// CONFIGURATION
//  `PIPE_CTRL_PERF_EN defined: stall_cycles increments by 1 every cycle stall!=0, saturates at
//        32'hFFFF_FFFF, cleared only by reset.
//  Undefined: counter not built, stall_cycles tied to 32'h0 (port kept for stable interface).
// STRUCTURE
//  defines.v: `StallBus 5:0, `STALL_NONE 6'b000000, `STALL_ID 6'b000111, `STALL_EX 6'b001111,
//        FSM encodings `PCTRL_IDLE/_MC_RUN/_MC_DONE/_FLUSH, `McLenBus.
//  Sub-module mc_down_counter (load, dec, count, at_one) instantiated once for the EX countdown.
//  Instantiated in ToruMIPS next to id_ex; stall[3]/stall[2] gate id_ex update, flush forces NOP.
// TESTING
//  1 reset: hold rst=0 with all inputs toggling -> all outputs 0; release -> IDLE, busy=0.
//  2 load-use: stallreq_id=1 for 2 cycles in IDLE -> stall=6'b000111 same cycles, then 0.
//  3 multi-cycle: ex_mc_start, len=5 -> stall=6'b001111 4 cycles, mc_done next cycle, then IDLE;
//    len=1 and len=0 -> no stall, mc_done next cycle.
//  4 abort: len=8, excp_req on 3rd stall cycle with excp_pc=0x0000_0040 -> next cycle flush=1,
//    new_pc=0x40, stall=0, no mc_done ever; IDLE after.
//  5 collision: excp_req + ex_mc_start same IDLE cycle -> FLUSH only; excp_req during FLUSH ignored.
//  6 perf (with PIPE_CTRL_PERF_EN): run tests 2+3 -> stall_cycles=6; without macro -> stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stall-bus encodings, FSM state enum and the per-state stall decode helper.
package pipe_ctrl_pkg;

   typedef logic [5:0] stall_bus_t;

   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_ID   = 6'b000111;
   localparam stall_bus_t STALL_EX   = 6'b001111;

   typedef enum logic [1:0] {
      PCTRL_IDLE    = 2'd0,
      PCTRL_MC_RUN  = 2'd1,
      PCTRL_MC_DONE = 2'd2,
      PCTRL_FLUSH   = 2'd3
   } pctrl_state_e;

   // A running multi-cycle op already holds PC..EX, so a load-use request adds nothing.
   function automatic stall_bus_t stall_for_state(input pctrl_state_e state, input logic stallreq_id);
      stall_bus_t s;
      s = STALL_NONE;
      case (state)
         PCTRL_MC_RUN:                s = STALL_EX;
         PCTRL_IDLE, PCTRL_MC_DONE:   s = stallreq_id ? STALL_ID : STALL_NONE;
         default:                     s = STALL_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/pipe_ctrl_mc_down_counter.sv
// Loadable down-counter sequencing EX multi-cycle ops; stops at 1 and never wraps.
module pipe_ctrl_mc_down_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         at_one
);

   logic [W-1:0] count_q, count_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (dec && count_q > W'(1))
         count_d = count_q - W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count  = count_q;
   assign at_one = (count_q == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, EX multi-cycle sequencing, exception flush.
// Optional stall-cycle performance counter built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W  = 6,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              ex_mc_start,
   input  logic [CNT_W-1:0]  ex_mc_len,
   input  logic              excp_req,
   input  logic [ADDR_W-1:0] excp_pc,
   output logic [5:0]        stall,
   output logic              flush,
   output logic [ADDR_W-1:0] new_pc,
   output logic              mc_done,
   output logic              busy,
   output logic [31:0]       stall_cycles
);

   pctrl_state_e      state_q, state_d;
   logic [ADDR_W-1:0] new_pc_q, new_pc_d;
   logic              cnt_load, cnt_dec, cnt_at_one;
   logic [CNT_W-1:0]  cnt_load_val, cnt_value;

   pipe_ctrl_mc_down_counter #(.W(CNT_W)) u_mc_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (cnt_value),
      .at_one   (cnt_at_one)
   );

   always_comb begin
      state_d      = state_q;
      new_pc_d     = new_pc_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      case (state_q)
         PCTRL_IDLE: begin
            if (excp_req) begin
               state_d  = PCTRL_FLUSH;
               new_pc_d = excp_pc;
            end else if (ex_mc_start) begin
               // len 0 and 1 both finish in the issue cycle itself.
               if (ex_mc_len >= CNT_W'(2)) begin
                  state_d      = PCTRL_MC_RUN;
                  cnt_load     = 1'b1;
                  cnt_load_val = ex_mc_len - CNT_W'(1);
               end else begin
                  state_d = PCTRL_MC_DONE;
               end
            end
         end
         PCTRL_MC_RUN: begin
            if (excp_req) begin
               state_d  = PCTRL_FLUSH;
               new_pc_d = excp_pc;
               cnt_load = 1'b1;
            end else if (cnt_at_one) begin
               state_d = PCTRL_MC_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         PCTRL_MC_DONE: begin
            if (excp_req) begin
               state_d  = PCTRL_FLUSH;
               new_pc_d = excp_pc;
            end else begin
               state_d = PCTRL_IDLE;
            end
         end
         default: state_d = PCTRL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= PCTRL_IDLE;
         new_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         new_pc_q <= new_pc_d;
      end
   end

   // Stall is forced low while reset is held so downstream regs see a quiet bus.
   assign stall   = rst ? stall_for_state(state_q, stallreq_id) : STALL_NONE;
   assign flush   = (state_q == PCTRL_FLUSH);
   assign new_pc  = new_pc_q;
   assign mc_done = (state_q == PCTRL_MC_DONE);
   assign busy    = (state_q != PCTRL_IDLE);

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (stall != STALL_NONE && perf_q != 32'hFFFF_FFFF)
         perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_q <= '0;
      else      perf_q <= perf_d;
   end

   assign stall_cycles = perf_q;
`else
   assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id;
   logic        ex_mc_start;
   logic [5:0]  ex_mc_len;
   logic        excp_req;
   logic [31:0] excp_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_done;
   logic        busy;
   logic [31:0] stall_cycles;

   int n_cmp = 0;
   int n_bad = 0;
   int vec_idx = 0;
   int unsigned perf_model = 0;

   typedef struct {
      int          idx;
      logic        rst;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        done;
      logic        busy;
   } exp_t;

   exp_t sb[$];

   pipe_ctrl #(.CNT_W(6), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .ex_mc_start  (ex_mc_start),
      .ex_mc_len    (ex_mc_len),
      .excp_req     (excp_req),
      .excp_pc      (excp_pc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .mc_done      (mc_done),
      .busy         (busy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
   task automatic vec(input logic r, input logic sreq, input logic st, input logic [5:0] len,
                      input logic ex, input logic [31:0] pc,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_done, input logic e_busy);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      stallreq_id = sreq;
      ex_mc_start = st;
      ex_mc_len   = len;
      excp_req    = ex;
      excp_pc     = pc;
      e.idx   = vec_idx;
      e.rst   = r;
      e.stall = e_stall;
      e.flush = e_flush;
      e.pc    = e_pc;
      e.done  = e_done;
      e.busy  = e_busy;
      sb.push_back(e);
      vec_idx++;
   endtask

   initial begin : monitor
      exp_t e;
      logic [31:0] exp_perf;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.rst) perf_model = 0;
            check("stall",   e.idx, {26'd0, stall}, {26'd0, e.stall});
            check("flush",   e.idx, {31'd0, flush}, {31'd0, e.flush});
            check("mc_done", e.idx, {31'd0, mc_done}, {31'd0, e.done});
            check("busy",    e.idx, {31'd0, busy}, {31'd0, e.busy});
            if (e.flush) check("new_pc", e.idx, new_pc, e.pc);
            if (!e.rst) check("new_pc_rst", e.idx, new_pc, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
            exp_perf = perf_model;
`else
            exp_perf = 32'h0;
`endif
            check("stall_cycles", e.idx, stall_cycles, exp_perf);
            if (e.rst && e.stall != 6'd0) perf_model++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      rst = 1'b0; stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_len = '0;
      excp_req = 1'b0; excp_pc = '0;

      //   rst sreq st len    ex pc            stall      fl  new_pc        dn  busy
      // reset held with inputs toggling
      vec(0, 1, 1, 6'd5, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(0, 0, 0, 6'd0, 1, 32'h1234,     6'b000000, 0, 32'h0,        0, 0);
      vec(0, 1, 1, 6'd3, 1, 32'h5678,     6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // load-use in IDLE for two cycles
      vec(1, 1, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 32'h0,        0, 0);
      vec(1, 1, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // len=5: issue cycle, 4 EX stalls (sreq and a new start absorbed), done, idle
      vec(1, 0, 1, 6'd5, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 1, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 0, 1, 6'd3, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // len=1 then len=0: no EX stall, done next cycle
      vec(1, 0, 1, 6'd1, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 1);
      vec(1, 0, 1, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 1, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 32'h0,        1, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // len=8 aborted by exception on third stall cycle; requests during FLUSH ignored
      vec(1, 0, 1, 6'd8, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 0, 0, 6'd0, 1, 32'h40,       6'b001111, 0, 32'h0,        0, 1);
      vec(1, 1, 1, 6'd4, 1, 32'h80,       6'b000000, 1, 32'h40,       0, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // exception and start collide in IDLE; second exception during FLUSH ignored
      vec(1, 0, 1, 6'd4, 1, 32'h100,      6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 1, 32'h200,      6'b000000, 1, 32'h100,      0, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // len=2 single stall, exception during MC_DONE still flushes
      vec(1, 0, 1, 6'd2, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(1, 0, 0, 6'd0, 1, 32'h300,      6'b000000, 0, 32'h0,        1, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 1, 32'h300,      0, 1);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      // reset mid-op aborts: no mc_done, no flush afterwards
      vec(1, 0, 1, 6'd6, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
      vec(0, 1, 0, 6'd0, 1, 32'h500,      6'b000000, 0, 32'h0,        0, 0);
      vec(1, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
      for (int i = 0; i < 6; i++)
         vec(1, 0, 0, 6'd0, 0, 32'h0,     6'b000000, 0, 32'h0,        0, 0);

      repeat (3) @(posedge clk);
      check("sb_drain", -1, sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
